// File: rtl/axil_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : axil_mem_responder
// Brief    : AXI4-Lite slave word memory with byte strobes, independent AW/W
//            capture, registered B response and a fixed-latency read pipeline.
//            Define MEM_RESP_SLVERR_EN to answer out-of-range indices with
//            SLVERR; otherwise the word index wraps modulo MEM_DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
module axil_mem_responder #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int MEM_DEPTH          = 512,
    parameter int RD_LATENCY         = 1
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int         c_IDX_W       = $clog2(MEM_DEPTH);
    localparam int         c_STRB_W      = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [2:0] c_RD_LAT      = 3'(RD_LATENCY);
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_WAIT = 2'd2,
        R_DATA = 2'd3
    } rd_state_t;

    logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Write channel state
    wr_state_t                     r_wr_state,  w_wr_state_nxt;
    logic                          r_aw_held,   w_aw_held_nxt;
    logic                          r_w_held,    w_w_held_nxt;
    logic [C_S_AXI_ADDR_WIDTH-1:0] r_awaddr,    w_awaddr_nxt;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata,     w_wdata_nxt;
    logic [c_STRB_W-1:0]           r_wstrb,     w_wstrb_nxt;
    logic                          r_awready,   w_awready_nxt;
    logic                          r_wready,    w_wready_nxt;
    logic                          r_bvalid,    w_bvalid_nxt;
    logic [1:0]                    r_bresp,     w_bresp_nxt;
    logic                          w_commit;

    // Read channel state
    rd_state_t                     r_rd_state,  w_rd_state_nxt;
    logic [C_S_AXI_ADDR_WIDTH-1:0] r_araddr,    w_araddr_nxt;
    logic                          r_arready,   w_arready_nxt;
    logic                          r_rvalid,    w_rvalid_nxt;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata,     w_rdata_nxt;
    logic [1:0]                    r_rresp,     w_rresp_nxt;
    logic [2:0]                    r_rcnt,      w_rcnt_nxt;

    logic                          w_aw_hs, w_w_hs, w_ar_hs;
    logic                          w_wr_oor, w_rd_oor;
    logic [c_IDX_W-1:0]            w_wr_idx, w_rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_word;
    logic                          w_unused;

    assign w_aw_hs   = S_AXI_AWVALID && r_awready;
    assign w_w_hs    = S_AXI_WVALID  && r_wready;
    assign w_ar_hs   = S_AXI_ARVALID && r_arready;
    assign w_wr_idx  = r_awaddr[c_IDX_W+1:2];
    assign w_rd_idx  = r_araddr[c_IDX_W+1:2];
    assign w_rd_word = r_mem[w_rd_idx];

`ifdef MEM_RESP_SLVERR_EN
    assign w_wr_oor = (32'(r_awaddr[C_S_AXI_ADDR_WIDTH-1:2]) >= 32'(MEM_DEPTH));
    assign w_rd_oor = (32'(r_araddr[C_S_AXI_ADDR_WIDTH-1:2]) >= 32'(MEM_DEPTH));
`else
    assign w_wr_oor = 1'b0;
    assign w_rd_oor = 1'b0;
`endif

    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, r_awaddr, r_araddr};

    // ------------------------------------------------------------------
    // Write FSM: next-state and register updates
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_aw_held_nxt  = r_aw_held;
        w_w_held_nxt   = r_w_held;
        w_awaddr_nxt   = r_awaddr;
        w_wdata_nxt    = r_wdata;
        w_wstrb_nxt    = r_wstrb;
        w_awready_nxt  = r_awready;
        w_wready_nxt   = r_wready;
        w_bvalid_nxt   = r_bvalid;
        w_bresp_nxt    = r_bresp;
        w_commit       = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (w_aw_hs) begin
                    w_aw_held_nxt = 1'b1;
                    w_awaddr_nxt  = S_AXI_AWADDR;
                end
                if (w_w_hs) begin
                    w_w_held_nxt = 1'b1;
                    w_wdata_nxt  = S_AXI_WDATA;
                    w_wstrb_nxt  = S_AXI_WSTRB;
                end
                w_awready_nxt = !(r_aw_held || w_aw_hs);
                w_wready_nxt  = !(r_w_held  || w_w_hs);
                if (r_aw_held && r_w_held) begin
                    w_commit       = 1'b1;
                    w_bvalid_nxt   = 1'b1;
                    w_bresp_nxt    = w_wr_oor ? c_RESP_SLVERR : c_RESP_OKAY;
                    w_wr_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_bvalid_nxt   = 1'b0;
                    w_aw_held_nxt  = 1'b0;
                    w_w_held_nxt   = 1'b0;
                    w_awready_nxt  = 1'b1;
                    w_wready_nxt   = 1'b1;
                    w_wr_state_nxt = W_IDLE;
                end
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_wr_state <= W_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= c_RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_aw_held  <= w_aw_held_nxt;
            r_w_held   <= w_w_held_nxt;
            r_awaddr   <= w_awaddr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_wstrb    <= w_wstrb_nxt;
            r_awready  <= w_awready_nxt;
            r_wready   <= w_wready_nxt;
            r_bvalid   <= w_bvalid_nxt;
            r_bresp    <= w_bresp_nxt;
        end
    end

    // Memory array is never reset; only strobed bytes of in-range words change.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_commit && !w_wr_oor) begin
            for (int b = 0; b < c_STRB_W; b++) begin
                if (r_wstrb[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM: R_ADDR samples the array, R_WAIT pads out the latency
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_araddr_nxt   = r_araddr;
        w_arready_nxt  = r_arready;
        w_rvalid_nxt   = r_rvalid;
        w_rdata_nxt    = r_rdata;
        w_rresp_nxt    = r_rresp;
        w_rcnt_nxt     = r_rcnt;
        case (r_rd_state)
            R_IDLE: begin
                w_arready_nxt = 1'b1;
                if (w_ar_hs) begin
                    w_araddr_nxt   = S_AXI_ARADDR;
                    w_arready_nxt  = 1'b0;
                    w_rd_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                // A concurrent write commit wins; the sample slips one cycle.
                if (!w_commit) begin
                    w_rdata_nxt = w_rd_oor ? '0 : w_rd_word;
                    w_rresp_nxt = w_rd_oor ? c_RESP_SLVERR : c_RESP_OKAY;
                    if (c_RD_LAT == 3'd1) begin
                        w_rvalid_nxt   = 1'b1;
                        w_rd_state_nxt = R_DATA;
                    end else begin
                        w_rcnt_nxt     = 3'd2;
                        w_rd_state_nxt = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_rcnt == c_RD_LAT) begin
                    w_rvalid_nxt   = 1'b1;
                    w_rd_state_nxt = R_DATA;
                end else begin
                    w_rcnt_nxt = 3'(r_rcnt + 3'd1);
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    w_rvalid_nxt   = 1'b0;
                    w_arready_nxt  = 1'b1;
                    w_rd_state_nxt = R_IDLE;
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_rd_state <= R_IDLE;
            r_araddr   <= '0;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= c_RESP_OKAY;
            r_rcnt     <= 3'd0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_araddr   <= w_araddr_nxt;
            r_arready  <= w_arready_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_rdata    <= w_rdata_nxt;
            r_rresp    <= w_rresp_nxt;
            r_rcnt     <= w_rcnt_nxt;
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axil_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_mem_responder
// Brief    : Directed self-checking bench for axil_mem_responder (latency 1
//            instance plus a latency 3 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_mem_responder;

    localparam int AW = 12;

    logic tb_ACLK = 1'b0;
    logic tb_ARESET = 1'b1;
    always #5 tb_ACLK = ~tb_ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Latency-1 instance
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [2:0]    awprot = '0, arprot = '0;
    logic          awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;

    // Latency-3 instance
    logic [AW-1:0] l3_awaddr = '0, l3_araddr = '0;
    logic          l3_awvalid = 0, l3_wvalid = 0, l3_bready = 0, l3_arvalid = 0, l3_rready = 0;
    logic [31:0]   l3_wdata = '0;
    logic [3:0]    l3_wstrb = '0;
    logic          l3_awready, l3_wready, l3_bvalid, l3_arready, l3_rvalid;
    logic [1:0]    l3_bresp, l3_rresp;
    logic [31:0]   l3_rdata;

    axil_mem_responder #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW),
                         .MEM_DEPTH(512), .RD_LATENCY(1)) u_dut (
        .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESET(tb_ARESET),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready)
    );

    axil_mem_responder #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW),
                         .MEM_DEPTH(512), .RD_LATENCY(3)) u_dut_l3 (
        .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESET(tb_ARESET),
        .S_AXI_AWADDR(l3_awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(l3_awvalid),
        .S_AXI_AWREADY(l3_awready), .S_AXI_WDATA(l3_wdata), .S_AXI_WSTRB(l3_wstrb),
        .S_AXI_WVALID(l3_wvalid), .S_AXI_WREADY(l3_wready), .S_AXI_BRESP(l3_bresp),
        .S_AXI_BVALID(l3_bvalid), .S_AXI_BREADY(l3_bready), .S_AXI_ARADDR(l3_araddr),
        .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(l3_arvalid), .S_AXI_ARREADY(l3_arready),
        .S_AXI_RDATA(l3_rdata), .S_AXI_RRESP(l3_rresp), .S_AXI_RVALID(l3_rvalid),
        .S_AXI_RREADY(l3_rready)
    );

    task automatic tick();
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_done, w_done, aw_hs, w_hs;
        int   n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1; wvalid = 1; aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick(); n++;
            if (aw_hs) begin awvalid = 0; aw_done = 1; end
            if (w_hs)  begin wvalid = 0;  w_done = 1;  end
        end
        awvalid = 0; wvalid = 0;
        bready = 1; n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        if (!bvalid) begin
            n_checks++; n_fail++;
            $display("FAIL write_timeout addr=%h: bvalid=%b required 1", addr, bvalid);
        end
        resp = bresp;
        tick();
        bready = 0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        int n;
        araddr = addr; arvalid = 1; n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        tick();
        arvalid = 0; lat = 0;
        do begin tick(); lat++; end while (!rvalid && lat < 20);
        if (!rvalid) begin
            n_checks++; n_fail++;
            $display("FAIL read_timeout addr=%h: rvalid=%b required 1", addr, rvalid);
        end
        data = rdata; resp = rresp;
        rready = 1;
        tick();
        rready = 0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks++;
        if ({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got aw=%b w=%b b=%b br=%b ar=%b r=%b rr=%b rd=%h required all 0",
                     awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata);
        end
        tb_ARESET = 0;
        n_checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b required 000", {awready, wready, arready});
        end
        tick();
        n_checks++;
        if ({awready, wready, arready, l3_awready, l3_arready} !== 5'b11111) begin
            n_fail++;
            $display("FAIL ready_after_release: got %b required 11111",
                     {awready, wready, arready, l3_awready, l3_arready});
        end
    endtask

    task automatic test_basic();
        logic [1:0] r; logic [31:0] d; int lat;
        axi_write(12'h000, 32'h0101FFFF, 4'hF, r);
        n_checks++;
        if (r !== 2'b00) begin n_fail++; $display("FAIL basic_bresp: got %b required 00", r); end
        axi_read(12'h000, d, r, lat);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL basic_latency: got %0d required 1", lat); end
        n_checks++;
        if (d !== 32'h0101FFFF || r !== 2'b00) begin
            n_fail++; $display("FAIL basic_rdata: got %h/%b required 0101ffff/00", d, r);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] r; logic [31:0] d; int lat;
        wdata = 32'hABCD0001; wstrb = 4'hF; wvalid = 1;
        tick();
        wvalid = 0;
        n_checks++;
        if ({wready, awready} !== 2'b01) begin
            n_fail++; $display("FAIL w_first_ready: got w=%b aw=%b required 0 1", wready, awready);
        end
        tick(); tick();
        n_checks++;
        if (bvalid !== 1'b0) begin n_fail++; $display("FAIL w_first_no_b: got %b required 0", bvalid); end
        awaddr = 12'h004; awvalid = 1;
        tick();
        awvalid = 0;
        n_checks++;
        if (bvalid !== 1'b0) begin n_fail++; $display("FAIL w_first_b_early: got %b required 0", bvalid); end
        tick();
        n_checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            n_fail++; $display("FAIL w_first_b: got %b/%b required 1/00", bvalid, bresp);
        end
        bready = 1; tick(); bready = 0;
        axi_read(12'h004, d, r, lat);
        n_checks++;
        if (d !== 32'hABCD0001) begin n_fail++; $display("FAIL w_first_readback: got %h required abcd0001", d); end
    endtask

    task automatic test_strobe();
        logic [1:0] r; logic [31:0] d; int lat;
        axi_write(12'h008, 32'hBEEF0011, 4'hF, r);
        axi_write(12'h008, 32'h0000DEAD, 4'b0011, r);
        axi_read(12'h008, d, r, lat);
        n_checks++;
        if (d !== 32'hBEEFDEAD) begin n_fail++; $display("FAIL strobe_partial: got %h required beefdead", d); end
        axi_write(12'h008, 32'hFFFFFFFF, 4'b0000, r);
        n_checks++;
        if (r !== 2'b00) begin n_fail++; $display("FAIL strobe_zero_bresp: got %b required 00", r); end
        axi_read(12'h008, d, r, lat);
        n_checks++;
        if (d !== 32'hBEEFDEAD) begin n_fail++; $display("FAIL strobe_zero_data: got %h required beefdead", d); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        awaddr = 12'h010; wdata = 32'h5A5AA5A5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({bvalid, awready, wready} !== 3'b100) begin
                n_fail++; $display("FAIL bp_write_hold[%0d]: got %b required 100", i, {bvalid, awready, wready});
            end
            tick();
        end
        bready = 1; tick(); bready = 0;
        n_checks++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            n_fail++; $display("FAIL bp_write_release: got %b required 011", {bvalid, awready, wready});
        end
        araddr = 12'h010; arvalid = 1;
        tick();
        arvalid = 0;
        tick();
        held = rdata;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({rvalid, arready} !== 2'b10 || rdata !== 32'h5A5AA5A5 || rdata !== held) begin
                n_fail++; $display("FAIL bp_read_hold[%0d]: got v=%b ar=%b d=%h required 1 0 5a5aa5a5",
                                   i, rvalid, arready, rdata);
            end
            tick();
        end
        rready = 1; tick(); rready = 0;
        n_checks++;
        if ({rvalid, arready} !== 2'b01) begin
            n_fail++; $display("FAIL bp_read_release: got %b required 01", {rvalid, arready});
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] r; logic [31:0] d; int lat;
        axi_write(12'h800, 32'h12345678, 4'hF, r);
`ifdef MEM_RESP_SLVERR_EN
        n_checks++;
        if (r !== 2'b10) begin n_fail++; $display("FAIL oor_bresp: got %b required 10", r); end
        axi_read(12'h800, d, r, lat);
        n_checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            n_fail++; $display("FAIL oor_read: got %h/%b required 00000000/10", d, r);
        end
        axi_read(12'h000, d, r, lat);
        n_checks++;
        if (d !== 32'h0101FFFF) begin n_fail++; $display("FAIL oor_word0: got %h required 0101ffff", d); end
`else
        n_checks++;
        if (r !== 2'b00) begin n_fail++; $display("FAIL wrap_bresp: got %b required 00", r); end
        axi_read(12'h000, d, r, lat);
        n_checks++;
        if (d !== 32'h12345678 || r !== 2'b00) begin
            n_fail++; $display("FAIL wrap_word0: got %h/%b required 12345678/00", d, r);
        end
`endif
    endtask

    task automatic test_latency3();
        int lat;
        l3_awaddr = 12'h014; l3_wdata = 32'hCAFEF00D; l3_wstrb = 4'hF;
        l3_awvalid = 1; l3_wvalid = 1;
        tick();
        l3_awvalid = 0; l3_wvalid = 0;
        tick();
        n_checks++;
        if (l3_bvalid !== 1'b1) begin n_fail++; $display("FAIL lat3_bvalid: got %b required 1", l3_bvalid); end
        l3_bready = 1; tick(); l3_bready = 0;
        l3_araddr = 12'h014; l3_arvalid = 1;
        tick();
        l3_arvalid = 0; lat = 0;
        do begin tick(); lat++; end while (!l3_rvalid && lat < 20);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL lat3_latency: got %0d required 3", lat); end
        n_checks++;
        if (l3_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lat3_rdata: got %h required cafef00d", l3_rdata); end
        l3_rready = 1; tick(); l3_rready = 0;
    endtask

    task automatic test_collision();
        logic [1:0] r;
        axi_write(12'h00C, 32'h11111111, 4'hF, r);
        awaddr = 12'h00C; wdata = 32'hDEAD0011; wstrb = 4'hF; araddr = 12'h00C;
        awvalid = 1; wvalid = 1; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        tick();
        n_checks++;
        if ({bvalid, rvalid} !== 2'b10) begin
            n_fail++; $display("FAIL collision_slip: got b=%b r=%b required 1 0", bvalid, rvalid);
        end
        tick();
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hDEAD0011 || rresp !== 2'b00) begin
            n_fail++; $display("FAIL collision_data: got v=%b d=%h r=%b required 1 dead0011 00", rvalid, rdata, rresp);
        end
        rready = 1; tick(); rready = 0;
    endtask

    task automatic test_async_reset();
        logic [1:0] r; logic [31:0] d; int lat;
        n_checks++;
        if (bvalid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_bvalid: got %b required 1", bvalid); end
        #2;
        tb_ARESET = 1;
        #1;
        n_checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b00000) begin
            n_fail++; $display("FAIL areset_immediate: got %b required 00000",
                               {awready, wready, bvalid, arready, rvalid});
        end
        tick(); tick();
        tb_ARESET = 0;
        tick();
        n_checks++;
        if ({awready, wready, bvalid, arready} !== 4'b1101) begin
            n_fail++; $display("FAIL areset_recover: got %b required 1101", {awready, wready, bvalid, arready});
        end
        axi_read(12'h00C, d, r, lat);
        n_checks++;
        if (d !== 32'hDEAD0011) begin n_fail++; $display("FAIL areset_mem_kept: got %h required dead0011", d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_w_before_aw();
        test_strobe();
        test_backpressure();
        test_out_of_range();
        test_latency3();
        test_collision();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
